// File: rtl/mu0_sequencer_if.sv
// mu0_sequencer_if: control/handshake bundle between the MU0 sequencer and its
// datapath + memory.
//   master (sequencer): inputs Opcode, N, Z, MemAck;
//                       outputs MemReq, RnW, AddrSel, IRce, PCInc, PCce, ACCce,
//                       ALUfs, Halted, Fault
//   slave  (datapath/memory): the mirror image.
interface mu0_sequencer_if;
   logic [3:0] Opcode;
   logic       N;
   logic       Z;
   logic       MemAck;
   logic       MemReq;
   logic       RnW;
   logic       AddrSel;
   logic       IRce;
   logic       PCInc;
   logic       PCce;
   logic       ACCce;
   logic [1:0] ALUfs;
   logic       Halted;
   logic       Fault;

   modport master (
      input  Opcode, N, Z, MemAck,
      output MemReq, RnW, AddrSel, IRce, PCInc, PCce, ACCce, ALUfs, Halted, Fault
   );

   modport slave (
      output Opcode, N, Z, MemAck,
      input  MemReq, RnW, AddrSel, IRce, PCInc, PCce, ACCce, ALUfs, Halted, Fault
   );
endinterface

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 fetch/execute control FSM.
//   Clk     - system clock, rising edge
//   nReset  - asynchronous active-low reset
//   bus     - mu0_sequencer_if.master: Opcode/N/Z/MemAck in, datapath
//             enables, ALU function, memory req/ack, Halted/Fault out
// Parameters:
//   TIMEOUT - max consecutive unacknowledged MemReq cycles before FAULT (0 = off)
//   CNT_W   - timeout counter width, TIMEOUT must be <= 2**CNT_W-1
// Optional feature macro: MU0_ILLEGAL_TRAP_EN
//   defined   - opcodes 8-15 send the FSM to FAULT
//   undefined - opcodes 8-15 are single-cycle NOPs
// All outputs are decoded combinationally from the registered state, so they
// drop to 0 as soon as nReset is asserted.
module mu0_sequencer #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input logic             Clk,
   input logic             nReset,
   mu0_sequencer_if.master bus
);

   typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StFault} state_e;

   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

   state_e           r_state;
   state_e           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_timeout;

   logic       w_mem_req;
   logic       w_rnw;
   logic       w_addr_sel;
   logic       w_ir_ce;
   logic       w_pc_inc;
   logic       w_pc_ce;
   logic       w_acc_ce;
   logic [1:0] w_alu_fs;
   logic       w_halted;
   logic       w_fault;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Counter has waited the full budget; a missing ack this cycle means FAULT.
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == TimeoutCnt);

   always_comb begin
      w_state_next = r_state;
      w_mem_req    = 1'b0;
      w_rnw        = 1'b0;
      w_addr_sel   = 1'b0;
      w_ir_ce      = 1'b0;
      w_pc_inc     = 1'b0;
      w_pc_ce      = 1'b0;
      w_acc_ce     = 1'b0;
      w_alu_fs     = 2'b00;
      w_halted     = 1'b0;
      w_fault      = 1'b0;

      unique case (r_state)
         StIdle: w_state_next = StFetch;

         StFetch: begin
            w_mem_req = 1'b1;
            w_rnw     = 1'b1;
            if (bus.MemAck) begin
               w_ir_ce      = 1'b1;
               w_pc_inc     = 1'b1;
               w_state_next = StExec;
            end else if (w_timeout) begin
               w_state_next = StFault;
            end
         end

         StExec: begin
            case (bus.Opcode)
               // LDA / ADD / SUB: read operand at IR[11:0] into the ALU
               4'd0, 4'd2, 4'd3: begin
                  w_mem_req  = 1'b1;
                  w_rnw      = 1'b1;
                  w_addr_sel = 1'b1;
                  w_alu_fs   = (bus.Opcode == 4'd2) ? 2'b01 :
                               (bus.Opcode == 4'd3) ? 2'b10 : 2'b00;
                  if (bus.MemAck) begin
                     w_acc_ce     = 1'b1;
                     w_state_next = StFetch;
                  end else if (w_timeout) begin
                     w_state_next = StFault;
                  end
               end
               // STA: write ACC to IR[11:0]
               4'd1: begin
                  w_mem_req  = 1'b1;
                  w_addr_sel = 1'b1;
                  if (bus.MemAck) begin
                     w_state_next = StFetch;
                  end else if (w_timeout) begin
                     w_state_next = StFault;
                  end
               end
               4'd4: begin
                  w_pc_ce      = 1'b1;
                  w_state_next = StFetch;
               end
               4'd5: begin
                  w_pc_ce      = !bus.N;
                  w_state_next = StFetch;
               end
               4'd6: begin
                  w_pc_ce      = !bus.Z;
                  w_state_next = StFetch;
               end
               4'd7: w_state_next = StHalt;
               default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
                  w_state_next = StFault;
`else
                  w_state_next = StFetch;
`endif
               end
            endcase
         end

         StHalt: w_halted = 1'b1;

         StFault: begin
            w_halted = 1'b1;
            w_fault  = 1'b1;
         end

         default: w_state_next = StIdle;
      endcase
   end

   // Wait-cycle counter: restarts on any state change or ack, only advances
   // while a request is outstanding.
   always_comb begin
      w_cnt_next = r_cnt;
      if ((w_state_next != r_state) || bus.MemAck) begin
         w_cnt_next = '0;
      end else if (w_mem_req && (TIMEOUT != 0)) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   assign bus.MemReq  = w_mem_req;
   assign bus.RnW     = w_rnw;
   assign bus.AddrSel = w_addr_sel;
   assign bus.IRce    = w_ir_ce;
   assign bus.PCInc   = w_pc_inc;
   assign bus.PCce    = w_pc_ce;
   assign bus.ACCce   = w_acc_ce;
   assign bus.ALUfs   = w_alu_fs;
   assign bus.Halted  = w_halted;
   assign bus.Fault   = w_fault;

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: self-checking bench for mu0_sequencer (TIMEOUT=15, CNT_W=4).
// Observed outputs are packed as
//   {MemReq, RnW, AddrSel, IRce, PCInc, PCce, ACCce, ALUfs[1:0], Halted, Fault}
module tb_mu0_sequencer;

   localparam logic [10:0] MREQ  = 11'b100_0000_0000;
   localparam logic [10:0] RNW   = 11'b010_0000_0000;
   localparam logic [10:0] ASEL  = 11'b001_0000_0000;
   localparam logic [10:0] IRCE  = 11'b000_1000_0000;
   localparam logic [10:0] PCINC = 11'b000_0100_0000;
   localparam logic [10:0] PCCE  = 11'b000_0010_0000;
   localparam logic [10:0] ACCCE = 11'b000_0001_0000;
   localparam logic [10:0] FADD  = 11'b000_0000_0100;
   localparam logic [10:0] FSUB  = 11'b000_0000_1000;
   localparam logic [10:0] HALT  = 11'b000_0000_0010;
   localparam logic [10:0] FLT   = 11'b000_0000_0001;
   localparam logic [10:0] FW    = MREQ | RNW;                 // fetch, waiting
   localparam logic [10:0] FA    = MREQ | RNW | IRCE | PCINC;  // fetch, acked

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   mu0_sequencer_if bus ();

   mu0_sequencer #(
      .TIMEOUT (15),
      .CNT_W   (4)
   ) dut (
      .Clk    (clk),
      .nReset (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [10:0] obs;
   assign obs = {bus.MemReq, bus.RnW, bus.AddrSel, bus.IRce, bus.PCInc, bus.PCce,
                 bus.ACCce, bus.ALUfs, bus.Halted, bus.Fault};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int op, input logic n, input logic z, input logic ack);
      bus.Opcode = 4'(op);
      bus.N      = n;
      bus.Z      = z;
      bus.MemAck = ack;
   endtask

   // Reset, then step through IDLE so the caller starts in FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   // Zero-wait fetch of an instruction; leaves the sequencer in EXEC.
   task automatic fetch_ack();
      drive(int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
      #1;
      cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1);
         #1;
         total++;
         if (obs !== 11'd0) begin
            bad++;
            $display("FAIL reset_low cyc%0d: got %b want %b", i, obs, 11'd0);
         end
         cyc();
      end
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b1);
      #1;
      total++;
      if (obs !== 11'd0) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want %b", obs, 11'd0);
      end
      cyc();
      drive(0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== FW) begin
         bad++;
         $display("FAIL first_fetch_wait: got %b want %b", obs, FW);
      end
      cyc();
      drive(0, 1'b0, 1'b0, 1'b1);
      #1;
      total++;
      if (obs !== FA) begin
         bad++;
         $display("FAIL first_fetch_ack: got %b want %b", obs, FA);
      end
      cyc();
      drive(4, 1'b0, 1'b0, 1'b0);  // JMP back to FETCH
      #1;
      cyc();
   endtask

   task automatic test_lda_waits();
      logic [10:0] base;
      base = MREQ | RNW | ASEL;
      fetch_ack();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b0, (i == 2));
         #1;
         total++;
         if (obs !== ((i == 2) ? (base | ACCCE) : base)) begin
            bad++;
            $display("FAIL lda_cycle%0d: got %b want %b", i, obs,
                     (i == 2) ? (base | ACCCE) : base);
         end
         cyc();
      end
      drive(0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== FW) begin
         bad++;
         $display("FAIL lda_back_to_fetch: got %b want %b", obs, FW);
      end
   endtask

   task automatic test_decode();
      logic [10:0] want [3];
      want[0] = MREQ | ASEL;                        // STA
      want[1] = MREQ | RNW | ASEL | FADD | ACCCE;   // ADD
      want[2] = MREQ | RNW | ASEL | FSUB | ACCCE;   // SUB
      for (int i = 0; i < 3; i++) begin
         fetch_ack();
         drive(i + 1, 1'($urandom), 1'($urandom), 1'b1);
         #1;
         total++;
         if (obs !== want[i]) begin
            bad++;
            $display("FAIL decode_op%0d: got %b want %b", i + 1, obs, want[i]);
         end
         cyc();
         drive(0, 1'b0, 1'b0, 1'b0);
         #1;
         total++;
         if (obs !== FW) begin
            bad++;
            $display("FAIL decode_op%0d_return: got %b want %b", i + 1, obs, FW);
         end
      end
   endtask

   task automatic test_jumps();
      // {op, N, Z, expected PCce}
      int   ops [5] = '{4, 5, 5, 6, 6};
      logic ns  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic zs  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic pc  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         fetch_ack();
         drive(ops[i], ns[i], zs[i], 1'($urandom));  // stray ack must be ignored
         #1;
         total++;
         if (obs !== (pc[i] ? PCCE : 11'd0)) begin
            bad++;
            $display("FAIL jump%0d_op%0d: got %b want %b", i, ops[i], obs,
                     pc[i] ? PCCE : 11'd0);
         end
         cyc();
         drive(0, 1'b0, 1'b0, 1'b0);
         #1;
         total++;
         if (obs !== FW) begin
            bad++;
            $display("FAIL jump%0d_return: got %b want %b", i, obs, FW);
         end
      end
   endtask

   task automatic test_illegal();
      fetch_ack();
      drive(9, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 11'd0) begin
         bad++;
         $display("FAIL illegal_exec: got %b want %b", obs, 11'd0);
      end
      cyc();
      drive(0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
`ifdef MU0_ILLEGAL_TRAP_EN
      if (obs !== (HALT | FLT)) begin
         bad++;
         $display("FAIL illegal_trap: got %b want %b", obs, HALT | FLT);
      end
`else
      if (obs !== FW) begin
         bad++;
         $display("FAIL illegal_nop_return: got %b want %b", obs, FW);
      end
`endif
      do_reset();
   endtask

   task automatic test_stp();
      fetch_ack();
      drive(7, 1'b0, 1'b0, 1'b1);
      #1;
      total++;
      if (obs !== 11'd0) begin
         bad++;
         $display("FAIL stp_exec: got %b want %b", obs, 11'd0);
      end
      cyc();
      for (int i = 0; i < 20; i++) begin
         drive(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
         #1;
         total++;
         if (obs !== HALT) begin
            bad++;
            $display("FAIL stp_sticky cyc%0d: got %b want %b", i, obs, HALT);
         end
         cyc();
      end
      do_reset();
   endtask

   task automatic test_timeout();
      // 15 wait cycles then an ack is still in budget.
      for (int i = 0; i < 16; i++) begin
         drive(0, 1'b0, 1'b0, (i == 15));
         #1;
         total++;
         if (obs !== ((i == 15) ? FA : FW)) begin
            bad++;
            $display("FAIL timeout_edge cyc%0d: got %b want %b", i, obs,
                     (i == 15) ? FA : FW);
         end
         cyc();
      end
      drive(4, 1'b0, 1'b0, 1'b0);
      #1;
      cyc();
      // 16 unacknowledged cycles trip the fault.
      for (int i = 0; i < 16; i++) begin
         drive(0, 1'b0, 1'b0, 1'b0);
         #1;
         total++;
         if (obs !== FW) begin
            bad++;
            $display("FAIL timeout_wait cyc%0d: got %b want %b", i, obs, FW);
         end
         cyc();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b0, 1'($urandom));
         #1;
         total++;
         if (obs !== (HALT | FLT)) begin
            bad++;
            $display("FAIL timeout_fault cyc%0d: got %b want %b", i, obs, HALT | FLT);
         end
         cyc();
      end
      do_reset();
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b0, 1'b0);
         #1;
         total++;
         if (obs !== FW) begin
            bad++;
            $display("FAIL midwait_fetch cyc%0d: got %b want %b", i, obs, FW);
         end
         cyc();
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 11'd0) begin
         bad++;
         $display("FAIL midwait_async_reset: got %b want %b", obs, 11'd0);
      end
      do_reset();
   endtask

   // Random instruction stream against a per-instruction cycle-timeline model.
   task automatic test_random();
      logic        acks [$];
      logic [10:0] exps [$];
      int          op;
      int          wf;
      int          we;
      logic        n;
      logic        z;
      logic [10:0] base;
      logic        take;
      for (int k = 0; k < 120; k++) begin
         op = int'($urandom_range(0, 15));
         if (op == 7) op = 4;
`ifdef MU0_ILLEGAL_TRAP_EN
         if (op > 7) op = op - 8;
         if (op == 7) op = 5;
`endif
         wf = int'($urandom_range(0, 3));
         we = int'($urandom_range(0, 3));
         n  = 1'($urandom);
         z  = 1'($urandom);
         acks.delete();
         exps.delete();
         for (int i = 0; i < wf; i++) begin
            acks.push_back(1'b0);
            exps.push_back(FW);
         end
         acks.push_back(1'b1);
         exps.push_back(FA);
         if (op <= 3) begin
            base = MREQ | ASEL | ((op == 1) ? 11'd0 : RNW) |
                   ((op == 2) ? FADD : 11'd0) | ((op == 3) ? FSUB : 11'd0);
            for (int i = 0; i < we; i++) begin
               acks.push_back(1'b0);
               exps.push_back(base);
            end
            acks.push_back(1'b1);
            exps.push_back(base | ((op == 1) ? 11'd0 : ACCCE));
         end else if (op <= 6) begin
            take = (op == 4) ? 1'b1 : (op == 5) ? !n : !z;
            acks.push_back(1'($urandom));
            exps.push_back(take ? PCCE : 11'd0);
         end else begin
            acks.push_back(1'($urandom));
            exps.push_back(11'd0);
         end
         for (int c = 0; c < exps.size(); c++) begin
            // Opcode is garbage during the fetch phase; only EXEC may look at it.
            drive((c <= wf) ? int'($urandom_range(0, 15)) : op, n, z, acks[c]);
            #1;
            total++;
            if (obs !== exps[c]) begin
               bad++;
               $display("FAIL random instr%0d op%0d cyc%0d: got %b want %b",
                        k, op, c, obs, exps[c]);
            end
            cyc();
         end
      end
   endtask

   initial begin
      test_reset();
      test_lda_waits();
      test_decode();
      test_jumps();
      test_illegal();
      test_stp();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

endmodule
